// File: rtl/key_event_ctrl_if.sv
// Avalon-MM slave bus bundle for key_event_ctrl: word-addressed register
// access with a registered 32-bit read data return.
interface key_event_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/key_event_ctrl.sv
// Four-key push-button controller: synchronizes and debounces the raw levels,
// queues change events in a small FIFO, latches presses and raises a maskable irq.
module key_event_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  key_event_ctrl_if.slave   bus,
  input  logic [3:0]        in_port,
  output logic              irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       edge_q, edge_d;
  logic             irq_q, irq_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      rdata_q, rdata_d;

  logic       rd_s, wr_s, pop_s, flush_s, push_s, push_ok_s, full_s;
  logic [3:0] changed_s;
  logic       unused_wdata_s;

  assign rd_s      = bus.chipselect & bus.read;
  assign wr_s      = bus.chipselect & bus.write;
  assign full_s    = (count_q == FIFO_FULL);
  assign pop_s     = rd_s && (bus.address == 2'd3) && (count_q != {(PTR_W + 1){1'b0}});
  assign flush_s   = wr_s && (bus.address == 2'd3);
  assign changed_s = deb_d ^ deb_q;
  assign push_s    = |changed_s;
  // A full FIFO still accepts the push when the same cycle frees a slot.
  assign push_ok_s = push_s && (!full_s || pop_s) && !flush_s;

  assign unused_wdata_s = ^bus.writedata[31:4];
  assign bus.readdata   = rdata_q;
  assign irq            = irq_q;

  // Debounce: a key's level is accepted only after CNT_LAST+1 mismatching cycles.
  always_comb begin
    deb_d = deb_q;
    for (int k = 0; k < 4; k++) begin
      if (sync2_q[k] == deb_q[k]) begin
        cnt_d[k] = {CNT_W{1'b0}};
      end else if (cnt_q[k] == CNT_LAST) begin
        deb_d[k] = sync2_q[k];
        cnt_d[k] = {CNT_W{1'b0}};
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  // Mask, press latch (set beats write-1-clear) and interrupt.
  always_comb begin
    if (wr_s && (bus.address == 2'd1)) begin
      mask_d = bus.writedata[3:0];
    end else begin
      mask_d = mask_q;
    end
    if (wr_s && (bus.address == 2'd2)) begin
      edge_d = (edge_q & ~bus.writedata[3:0]) | (deb_q & ~deb_d);
    end else begin
      edge_d = edge_q | (deb_q & ~deb_d);
    end
    irq_d = |(edge_q & mask_q);
  end

  // Event FIFO bookkeeping; flush overrides any push or pop in the same cycle.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    count_d = count_q;
    ovf_d  = ovf_q;
    if (flush_s) begin
      wptr_d  = {PTR_W{1'b0}};
      rptr_d  = {PTR_W{1'b0}};
      count_d = {(PTR_W + 1){1'b0}};
      ovf_d   = 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_d[wptr_q] = {changed_s, deb_d};
        wptr_d        = wptr_q + PTR_W'(1);
      end else if (push_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + PTR_W'(1);
      end else begin
        rptr_d = rptr_q;
      end
      count_d = count_q + {{PTR_W{1'b0}}, push_ok_s} - {{PTR_W{1'b0}}, pop_s};
    end
  end

  // Read data mux, held between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_s) begin
      case (bus.address)
        2'd0:    rdata_d = {ovf_q, 10'b0, 5'(count_q), 12'b0, deb_q};
        2'd1:    rdata_d = {28'b0, mask_q};
        2'd2:    rdata_d = {28'b0, edge_q};
        2'd3:    rdata_d = pop_s ? {1'b1, 23'b0, mem_q[rptr_q]} : 32'b0;
        default: rdata_d = 32'b0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State registers; keys idle high so the reset level produces no event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      deb_q   <= 4'hF;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= {CNT_W{1'b0}};
      end
      mask_q  <= 4'h0;
      edge_q  <= 4'h0;
      irq_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wptr_q  <= {PTR_W{1'b0}};
      rptr_q  <= {PTR_W{1'b0}};
      count_q <= {(PTR_W + 1){1'b0}};
      ovf_q   <= 1'b0;
      rdata_q <= 32'b0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      irq_q   <= irq_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed self-checking bench for key_event_ctrl with DEBOUNCE_CYCLES=4 and
// FIFO_DEPTH=4: a table of glitch/press patterns plus timed corner sequences.
module tb_key_event_ctrl;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] in_port;
  logic       irq;

  key_event_ctrl_if bus();

  key_event_ctrl #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  pulse;
    int          len;
    logic [3:0]  rest;
    logic [31:0] exp_status;
    logic [31:0] exp_edge;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic access(input logic cs, input logic rd, input logic wr, input logic [1:0] a,
                        input logic [31:0] wd, output logic [31:0] rdv);
    @(negedge clk);
    bus.chipselect = cs;
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = a;
    bus.writedata  = wd;
    @(posedge clk);
    #1 rdv = bus.readdata;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] v;
    access(1'b1, 1'b0, 1'b1, a, d, v);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    access(1'b1, 1'b1, 1'b0, a, 32'h0, v);
    check(name, v, exp);
  endtask

  task automatic set_keys(input logic [3:0] v);
    @(negedge clk);
    in_port = v;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic cleanup();
    set_keys(4'hF);
    settle(12);
    wr(2'd3, 32'h0);
    wr(2'd2, 32'hF);
  endtask

  initial begin
    logic [31:0] v;

    vecs[0] = '{4'hD, 2, 4'hF, 32'h0000_000F, 32'h0};
    vecs[1] = '{4'hB, 3, 4'hF, 32'h0000_000F, 32'h0};
    vecs[2] = '{4'h7, 4, 4'hF, 32'h0002_000F, 32'h8};
    vecs[3] = '{4'hE, 10, 4'hE, 32'h0001_000E, 32'h1};
    vecs[4] = '{4'h6, 1, 4'h6, 32'h0001_0006, 32'h8};
    vecs[5] = '{4'hF, 1, 4'hF, 32'h0001_000F, 32'h0};

    reset_n        = 1'b0;
    in_port        = 4'hF;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = 2'd0;
    bus.writedata  = 32'h0;
    #23 reset_n = 1'b1;

    // Reset state
    settle(1);
    #1;
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    settle(10);
    rd_chk("reset_status", 2'd0, 32'h0000_000F);
    rd_chk("reset_mask", 2'd1, 32'h0);
    rd_chk("reset_edge", 2'd2, 32'h0);
    rd_chk("reset_event", 2'd3, 32'h0);

    // Table: glitch rejection boundary and multi-key level changes
    for (int i = 0; i < 6; i++) begin
      set_keys(vecs[i].pulse);
      settle(vecs[i].len);
      set_keys(vecs[i].rest);
      settle(12);
      rd_chk($sformatf("vec%0d_status", i), 2'd0, vecs[i].exp_status);
      rd_chk($sformatf("vec%0d_edge", i), 2'd2, vecs[i].exp_edge);
      wr(2'd2, 32'hF);
      wr(2'd3, 32'h0);
    end
    cleanup();

    // Key0 held low: level, edge, event word, empty read
    set_keys(4'hE);
    settle(10);
    rd_chk("k0_status", 2'd0, 32'h0001_000E);
    rd_chk("k0_edge", 2'd2, 32'h1);
    check("k0_irq_masked", {31'b0, irq}, 32'h0);
    rd_chk("k0_event", 2'd3, 32'h8000_001E);
    rd_chk("k0_event_empty", 2'd3, 32'h0);
    cleanup();

    // Mask, irq, edge clear, ignored accesses, readdata hold
    wr(2'd1, 32'h4);
    rd_chk("mask_rd", 2'd1, 32'h4);
    access(1'b0, 1'b1, 1'b0, 2'd2, 32'h0, v);
    check("no_cs_read_holds", v, 32'h4);
    access(1'b0, 1'b0, 1'b1, 2'd1, 32'hF, v);
    rd_chk("no_cs_write_ignored", 2'd1, 32'h4);
    wr(2'd0, 32'hFFFF_FFFF);
    rd_chk("addr0_write_ignored", 2'd0, 32'h0000_000F);
    set_keys(4'hB);
    settle(10);
    #1;
    check("irq_set", {31'b0, irq}, 32'h1);
    wr(2'd2, 32'h4);
    @(posedge clk);
    #1;
    check("irq_cleared", {31'b0, irq}, 32'h0);
    wr(2'd1, 32'h0);
    cleanup();

    // Same-cycle edge set and write-1-clear: set wins
    set_keys(4'hE);
    settle(5);
    wr(2'd2, 32'hF);
    rd_chk("edge_set_wins", 2'd2, 32'h1);
    // Same-cycle push and flush: flush wins
    set_keys(4'hF);
    settle(5);
    wr(2'd3, 32'h0);
    rd_chk("flush_wins", 2'd0, 32'h0000_000F);
    cleanup();

    // Overflow: five events, four kept in order
    for (int i = 0; i < 5; i++) begin
      set_keys((i % 2 == 0) ? 4'hE : 4'hF);
      settle(10);
    end
    rd_chk("ovf_status", 2'd0, 32'h8004_000E);
    for (int i = 0; i < 4; i++) begin
      rd_chk($sformatf("ovf_pop%0d", i), 2'd3, (i % 2 == 0) ? 32'h8000_001E : 32'h8000_001F);
    end
    rd_chk("ovf_pop_empty", 2'd3, 32'h0);
    rd_chk("ovf_sticky", 2'd0, 32'h8000_000E);
    wr(2'd3, 32'h0);
    rd_chk("ovf_flushed", 2'd0, 32'h0000_000E);
    cleanup();

    // Two keys released in one cycle share an event
    set_keys(4'h6);
    settle(12);
    wr(2'd3, 32'h0);
    set_keys(4'hF);
    settle(12);
    rd_chk("dual_release_event", 2'd3, 32'h8000_009F);
    rd_chk("dual_release_single", 2'd3, 32'h0);
    cleanup();

    // Push and pop in the same cycle when full, then when empty
    set_keys(4'hB); settle(10);
    set_keys(4'hF); settle(10);
    set_keys(4'hD); settle(10);
    set_keys(4'hF); settle(10);
    set_keys(4'hD);
    settle(5);
    rd_chk("full_pushpop_head", 2'd3, 32'h8000_004B);
    rd_chk("full_pushpop_status", 2'd0, 32'h0004_000D);
    rd_chk("full_pop1", 2'd3, 32'h8000_004F);
    rd_chk("full_pop2", 2'd3, 32'h8000_002D);
    rd_chk("full_pop3", 2'd3, 32'h8000_002F);
    rd_chk("full_pop4", 2'd3, 32'h8000_002D);
    rd_chk("full_pop_empty", 2'd3, 32'h0);
    set_keys(4'hF);
    settle(5);
    rd_chk("empty_pushpop", 2'd3, 32'h0);
    rd_chk("empty_pushpop_status", 2'd0, 32'h0001_000F);
    rd_chk("empty_pushpop_stored", 2'd3, 32'h8000_002F);
    cleanup();

    // Reset mid-operation with events queued
    wr(2'd1, 32'hF);
    set_keys(4'hE); settle(10);
    set_keys(4'hC); settle(10);
    set_keys(4'hF); settle(10);
    rd_chk("pre_reset_status", 2'd0, 32'h0003_000F);
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    #3 reset_n = 1'b0;
    #17 reset_n = 1'b1;
    #1;
    check("post_reset_irq", {31'b0, irq}, 32'h0);
    check("post_reset_readdata", bus.readdata, 32'h0);
    rd_chk("post_reset_status", 2'd0, 32'h0000_000F);
    rd_chk("post_reset_mask", 2'd1, 32'h0);
    rd_chk("post_reset_edge", 2'd2, 32'h0);
    rd_chk("post_reset_event", 2'd3, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
